// File: rtl/program_sequencer.sv
// Program counter with hold/increment/branch/jump/call/return/clear ops and a
// return-address stack; pc, stack count and sticky error flags are all registered.
module program_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int MEM_ADDR_SIZE  = 8,
  parameter int STACK_DEPTH    = 4,
  parameter int unsigned RESET_ADDR = 0,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [2:0]               op,
  input  logic [WORD_SIZE-1:0]     value,
  output logic [MEM_ADDR_SIZE-1:0] pc,
  output logic [CW-1:0]            stack_count,
  output logic                     stack_overflow,
  output logic                     stack_underflow
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [MEM_ADDR_SIZE-1:0] RST_PC = MEM_ADDR_SIZE'(RESET_ADDR);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_JUMP   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RETURN = 3'd5,
    OP_CLEAR  = 3'd6,
    OP_RSVD   = 3'd7
  } opcode_e;

  logic [MEM_ADDR_SIZE-1:0] r_pc;
  logic [CW-1:0]            r_count;
  logic                     r_overflow;
  logic                     r_underflow;
  logic [MEM_ADDR_SIZE-1:0] r_stack [STACK_DEPTH];

  opcode_e                  w_op;
  logic [MEM_ADDR_SIZE-1:0] w_pcInc;
  logic [MEM_ADDR_SIZE-1:0] w_offset;
  logic [MEM_ADDR_SIZE-1:0] w_target;
  logic [CW-1:0]            w_countM1;
  logic [IW-1:0]            w_pushIdx;
  logic [IW-1:0]            w_popIdx;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_unusedBits;

  assign w_op      = opcode_e'(op);
  assign w_pcInc   = r_pc + MEM_ADDR_SIZE'(1);
  assign w_countM1 = r_count - CW'(1);
  assign w_pushIdx = r_count[IW-1:0];
  assign w_popIdx  = w_countM1[IW-1:0];
  assign w_full    = (r_count == CW'(STACK_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = reset_n && (w_op == OP_CALL) && !w_full;
  assign w_unusedBits = ^{value, w_countM1};

  // Branch offset is sign-extended when narrower than pc, otherwise truncated.
  if (WORD_SIZE >= MEM_ADDR_SIZE) begin : g_truncOffset
    assign w_offset = value[MEM_ADDR_SIZE-1:0];
    assign w_target = value[MEM_ADDR_SIZE-1:0];
  end else begin : g_extendOffset
    assign w_offset = {{(MEM_ADDR_SIZE-WORD_SIZE){value[WORD_SIZE-1]}}, value};
    assign w_target = {{(MEM_ADDR_SIZE-WORD_SIZE){1'b0}}, value};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= RST_PC;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_INC:    r_pc <= w_pcInc;
        OP_BRANCH: r_pc <= r_pc + w_offset;
        OP_JUMP:   r_pc <= w_target;
        OP_CALL: begin
          if (w_full) begin
            r_pc       <= w_pcInc;
            r_overflow <= 1'b1;
          end else begin
            r_pc    <= w_target;
            r_count <= r_count + CW'(1);
          end
        end
        OP_RETURN: begin
          if (w_empty) begin
            r_pc        <= w_pcInc;
            r_underflow <= 1'b1;
          end else begin
            r_pc    <= r_stack[w_popIdx];
            r_count <= w_countM1;
          end
        end
        OP_CLEAR: begin
          r_pc        <= RST_PC;
          r_count     <= '0;
          r_overflow  <= 1'b0;
          r_underflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stack storage needs no reset; entries above the count are never read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_stack[w_pushIdx] <= w_pcInc;
    end
  end

  assign pc              = r_pc;
  assign stack_count     = r_count;
  assign stack_overflow  = r_overflow;
  assign stack_underflow = r_underflow;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed scoreboard bench for program_sequencer: stimulus queues expected
// state after each op, a negedge monitor pops and compares it.
module tb_program_sequencer;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, BRANCH = 3'd2, JUMP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  op = HOLD;
  logic [15:0] value = '0;
  logic [7:0]  pc;
  logic [2:0]  stack_count;
  logic        stack_overflow;
  logic        stack_underflow;

  expect_t expQ[$];
  int checks = 0;
  int failures = 0;

  program_sequencer #(
    .WORD_SIZE(16), .MEM_ADDR_SIZE(8), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .op(op),
    .value(value),
    .pc(pc),
    .stack_count(stack_count),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] ePc, input logic [2:0] eCnt,
                             input logic eOvf, input logic eUnf);
    checks++;
    if (pc !== ePc || stack_count !== eCnt || stack_overflow !== eOvf || stack_underflow !== eUnf) begin
      failures++;
      $display("[TB] FAIL %s: got pc=%02h cnt=%0d ovf=%b unf=%b, expected pc=%02h cnt=%0d ovf=%b unf=%b",
               name, pc, stack_count, stack_overflow, stack_underflow, ePc, eCnt, eOvf, eUnf);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [15:0] v,
                               input logic [7:0] ePc, input logic [2:0] eCnt,
                               input logic eOvf, input logic eUnf);
    expect_t e;
    @(negedge clock);
    op = o;
    value = v;
    @(posedge clock);
    e.name = name; e.pc = ePc; e.cnt = eCnt; e.ovf = eOvf; e.unf = eUnf;
    expQ.push_back(e);
  endtask

  // Each op's result is registered at the posedge, so it is compared at the following negedge.
  always @(negedge clock) begin
    while (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput(e.name, e.pc, e.cnt, e.ovf, e.unf);
    end
  end

  initial begin
    #3000;
    failures++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    checkOutput("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Async reset in the middle of a call chain, with a flag already set
    applyStimulus("ret_empty_pre", RET,  16'h0000, 8'h01, 3'd0, 1'b0, 1'b1);
    applyStimulus("call_20_pre",   CALL, 16'h0020, 8'h20, 3'd1, 1'b0, 1'b1);
    applyStimulus("call_40_pre",   CALL, 16'h0040, 8'h40, 3'd2, 1'b0, 1'b1);
    @(negedge clock);
    op = HOLD;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Increment wrap
    applyStimulus("jump_fe",  JUMP, 16'h00FE, 8'hFE, 3'd0, 1'b0, 1'b0);
    applyStimulus("inc_ff",   INC,  16'h0000, 8'hFF, 3'd0, 1'b0, 1'b0);
    applyStimulus("inc_wrap", INC,  16'h0000, 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus("inc_01",   INC,  16'h0000, 8'h01, 3'd0, 1'b0, 1'b0);

    // Branches, jump upper-bit masking, hold and reserved op
    applyStimulus("jump_masked", JUMP,   16'h120A, 8'h0A, 3'd0, 1'b0, 1'b0);
    applyStimulus("branch_neg3", BRANCH, 16'hFFFD, 8'h07, 3'd0, 1'b0, 1'b0);
    applyStimulus("branch_0100", BRANCH, 16'h0100, 8'h07, 3'd0, 1'b0, 1'b0);
    applyStimulus("branch_pos",  BRANCH, 16'h00FC, 8'h03, 3'd0, 1'b0, 1'b0);
    applyStimulus("hold",        HOLD,   16'h0055, 8'h03, 3'd0, 1'b0, 1'b0);
    applyStimulus("reserved",    RSVD,   16'h0055, 8'h03, 3'd0, 1'b0, 1'b0);

    // Nested call/return
    applyStimulus("jump_10",  JUMP, 16'h0010, 8'h10, 3'd0, 1'b0, 1'b0);
    applyStimulus("call_20",  CALL, 16'h0020, 8'h20, 3'd1, 1'b0, 1'b0);
    applyStimulus("call_30",  CALL, 16'h0030, 8'h30, 3'd2, 1'b0, 1'b0);
    applyStimulus("ret_21",   RET,  16'h0000, 8'h21, 3'd1, 1'b0, 1'b0);
    applyStimulus("ret_11",   RET,  16'h0000, 8'h11, 3'd0, 1'b0, 1'b0);

    // Fill the stack, overflow, then unwind with the flag sticky
    applyStimulus("fill_call1", CALL, 16'h0050, 8'h50, 3'd1, 1'b0, 1'b0);
    applyStimulus("fill_call2", CALL, 16'h0060, 8'h60, 3'd2, 1'b0, 1'b0);
    applyStimulus("fill_call3", CALL, 16'h0070, 8'h70, 3'd3, 1'b0, 1'b0);
    applyStimulus("fill_call4", CALL, 16'h0080, 8'h80, 3'd4, 1'b0, 1'b0);
    applyStimulus("ovf_call5",  CALL, 16'h0090, 8'h81, 3'd4, 1'b1, 1'b0);
    applyStimulus("unwind_1",   RET,  16'h0000, 8'h71, 3'd3, 1'b1, 1'b0);
    applyStimulus("unwind_2",   RET,  16'h0000, 8'h61, 3'd2, 1'b1, 1'b0);
    applyStimulus("unwind_3",   RET,  16'h0000, 8'h51, 3'd1, 1'b1, 1'b0);
    applyStimulus("unwind_4",   RET,  16'h0000, 8'h12, 3'd0, 1'b1, 1'b0);

    // Underflow, sticky across other ops, then CLEAR
    applyStimulus("clear_ovf",  CLEAR,  16'h0000, 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus("jump_05",    JUMP,   16'h0005, 8'h05, 3'd0, 1'b0, 1'b0);
    applyStimulus("ret_empty",  RET,    16'h0000, 8'h06, 3'd0, 1'b0, 1'b1);
    applyStimulus("unf_sticky", BRANCH, 16'h0005, 8'h0B, 3'd0, 1'b0, 1'b1);
    applyStimulus("call_after", CALL,   16'h0033, 8'h33, 3'd1, 1'b0, 1'b1);
    applyStimulus("clear_unf",  CLEAR,  16'h0000, 8'h00, 3'd0, 1'b0, 1'b0);

    @(negedge clock);
    op = HOLD;
    repeat (3) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
